// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line stage: paces bits, pulls them from the shifter, bit-stuffs, NRZI-encodes
// onto D+/D- and appends SE0/SE0/J as the EOP. Line outputs update once per bit period.
module usb_tx_line_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_start,
  input  logic serial_in,
  input  logic send_eop,
  output logic shift_enable,
  output logic dplus_out,
  output logic dminus_out,
  output logic tx_busy,
  output logic eop_done
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int EOP_W  = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    STUFF   = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ONES_W-1:0]  ones_q;
  logic [ONES_W-1:0]  ones_d;
  logic [EOP_W-1:0]   eop_cnt_q;
  logic               dp_q;
  logic               dm_q;
  logic               busy_q;
  logic               tick;

  assign tick   = (state_q != IDLE) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign ones_d = ones_q + 1'b1;

  // Decoded so the shifter advances on the same edge that registers the encoded bit.
  assign shift_enable = (state_q == DATA) && tick && !send_eop;
  assign eop_done     = (state_q == EOP_J) && tick;

  assign dplus_out  = dp_q;
  assign dminus_out = dm_q;
  assign tx_busy    = busy_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      eop_cnt_q <= '0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (state_q == IDLE || tick) cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          dp_q      <= 1'b1;
          dm_q      <= 1'b0;
          ones_q    <= '0;
          eop_cnt_q <= '0;
          if (tx_start) begin
            state_q <= DATA;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            if (send_eop) begin
              dp_q      <= 1'b0;
              dm_q      <= 1'b0;
              eop_cnt_q <= '0;
              state_q   <= EOP_SE0;
            end else if (!serial_in) begin
              // Line is always J or K here, so a swap is the NRZI toggle.
              dp_q   <= dm_q;
              dm_q   <= dp_q;
              ones_q <= '0;
            end else begin
              ones_q <= ones_d;
              if (ones_d == ONES_W'(STUFF_LIMIT)) state_q <= STUFF;
            end
          end
        end
        STUFF: begin
          if (tick) begin
            dp_q    <= dm_q;
            dm_q    <= dp_q;
            ones_q  <= '0;
            state_q <= DATA;
          end
        end
        EOP_SE0: begin
          if (tick) begin
            if (eop_cnt_q == EOP_W'(EOP_SE0_BITS - 1)) begin
              dp_q      <= 1'b1;
              dm_q      <= 1'b0;
              eop_cnt_q <= '0;
              state_q   <= EOP_J;
            end else begin
              eop_cnt_q <= eop_cnt_q + 1'b1;
            end
          end
        end
        EOP_J: begin
          if (tick) begin
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: per-cycle trace compared against a bit-level symbol model.
module tb_usb_tx_line_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst, tx_start, serial_in, send_eop;
  logic shift_enable, dplus_out, dminus_out, tx_busy, eop_done;

  int checks = 0;
  int errors = 0;

  bit         pkt[$];
  logic [1:0] sym_line[$];
  bit         sym_data[$];
  logic [1:0] obs_line[$];
  logic       obs_se[$], obs_done[$], obs_busy[$];

  always #5 clk = ~clk;

  usb_tx_line_encoder #(.CLKS_PER_BIT(8), .STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .serial_in(serial_in),
    .send_eop(send_eop), .shift_enable(shift_enable), .dplus_out(dplus_out),
    .dminus_out(dminus_out), .tx_busy(tx_busy), .eop_done(eop_done)
  );

  // Line symbol per bit period: data bits (NRZI), stuffed zeros after six 1s, then SE0 SE0 J.
  function automatic void build_model();
    logic [1:0] line = LJ;
    int ones = 0;
    sym_line.delete();
    sym_data.delete();
    foreach (pkt[i]) begin
      if (pkt[i] == 1'b0) begin
        line = (line == LJ) ? LK : LJ;
        ones = 0;
      end else begin
        ones++;
      end
      sym_line.push_back(line); sym_data.push_back(1'b1);
      if (ones == 6) begin
        line = (line == LJ) ? LK : LJ;
        sym_line.push_back(line); sym_data.push_back(1'b0);
        ones = 0;
      end
    end
    sym_line.push_back(LSE0); sym_data.push_back(1'b0);
    sym_line.push_back(LSE0); sym_data.push_back(1'b0);
    sym_line.push_back(LJ);   sym_data.push_back(1'b0);
  endfunction

  // Sample s is taken at the negedge after the s-th rising edge following tx_start.
  function automatic logic [1:0] exp_line(int s);
    int n = sym_line.size();
    if (s <= CPB || s > CPB * n + CPB) return LJ;
    return sym_line[(s - CPB - 1) / CPB];
  endfunction

  function automatic logic exp_se(int s);
    int n = sym_line.size();
    if (s % CPB != 0 || s < CPB || s > CPB * n) return 1'b0;
    return sym_data[s / CPB - 1];
  endfunction

  function automatic logic exp_done(int s);
    return s == CPB * sym_line.size() + CPB;
  endfunction

  function automatic logic exp_busy(int s);
    return s <= CPB * sym_line.size() + CPB;
  endfunction

  // Acts as the upstream shifter and TX controller; records one sample per cycle until idle.
  task automatic run_packet(input int inject_at);
    int idx = 0;
    logic se;
    obs_line.delete(); obs_se.delete(); obs_done.delete(); obs_busy.delete();
    @(negedge clk);
    tx_start  = 1'b1;
    send_eop  = 1'b0;
    serial_in = pkt[0];
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int s = 1; s <= 2000; s++) begin
      @(negedge clk);
      obs_line.push_back({dplus_out, dminus_out});
      obs_se.push_back(shift_enable);
      obs_done.push_back(eop_done);
      obs_busy.push_back(tx_busy);
      se = shift_enable;
      if (!tx_busy) return;
      @(posedge clk); #1;
      if (se === 1'b1) idx++;
      serial_in = (idx < pkt.size()) ? pkt[idx] : 1'($urandom);
      send_eop  = (idx >= pkt.size());
      tx_start  = (s == inject_at);
    end
    checks++;
    errors++;
    $display("FAIL run_packet_timeout: tx_busy=%b after 2000 cycles, required 0", tx_busy);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_start = 1'b0; serial_in = 1'b0; send_eop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dplus_out, dminus_out, tx_busy, shift_enable, eop_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_state: dp,dm,busy,se,done=%b required 10000",
               {dplus_out, dminus_out, tx_busy, shift_enable, eop_done});
    end
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({dplus_out, dminus_out, tx_busy, shift_enable, eop_done} !== 5'b10000) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: dp,dm,busy,se,done=%b required 10000", i,
                 {dplus_out, dminus_out, tx_busy, shift_enable, eop_done});
      end
    end
  endtask

  task automatic test_sync();
    int n, bad = 0, pulses = 0;
    pkt = '{0, 0, 0, 0, 0, 0, 0, 1};
    sym_line = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LSE0, LSE0, LJ};
    sym_data = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    run_packet(0);
    n = CPB * sym_line.size() + CPB + 1;
    checks++;
    if (obs_line.size() != n) begin
      errors++; $display("FAIL sync_length: %0d samples, required %0d", obs_line.size(), n);
    end
    for (int s = 1; s <= obs_line.size() && s <= n && bad < 8; s++) begin
      checks++;
      if (obs_line[s-1] !== exp_line(s)) begin
        errors++; bad++; $display("FAIL sync_line s=%0d: %b required %b", s, obs_line[s-1], exp_line(s));
      end
      checks++;
      if (obs_se[s-1] !== exp_se(s)) begin
        errors++; bad++; $display("FAIL sync_shift s=%0d: %b required %b", s, obs_se[s-1], exp_se(s));
      end
      if (obs_se[s-1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 8) begin
      errors++; $display("FAIL sync_pulse_count: %0d required 8", pulses);
    end
  endtask

  task automatic test_stuffing();
    int n, bad = 0;
    pkt = '{0, 1, 1, 1, 1, 1, 1, 1};
    sym_line = '{LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LSE0, LSE0, LJ};
    sym_data = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0};
    run_packet(0);
    n = CPB * sym_line.size() + CPB + 1;
    checks++;
    if (obs_line.size() != n) begin
      errors++; $display("FAIL stuff_length: %0d samples, required %0d", obs_line.size(), n);
    end
    for (int s = 1; s <= obs_line.size() && s <= n && bad < 8; s++) begin
      checks++;
      if (obs_line[s-1] !== exp_line(s)) begin
        errors++; bad++; $display("FAIL stuff_line s=%0d: %b required %b", s, obs_line[s-1], exp_line(s));
      end
      checks++;
      if (obs_se[s-1] !== exp_se(s)) begin
        errors++; bad++; $display("FAIL stuff_shift s=%0d: %b required %b", s, obs_se[s-1], exp_se(s));
      end
    end
  endtask

  task automatic test_eop();
    int se0 = 0, jcnt = 0, dones = 0, eop_shifts = 0, first_se0 = -1, last_se0 = -1, last;
    pkt = '{0};
    run_packet(0);
    last = obs_line.size() - 1;
    foreach (obs_line[i]) begin
      if (obs_line[i] === LSE0) begin
        se0++;
        if (first_se0 < 0) first_se0 = i;
        last_se0 = i;
      end
      if (obs_done[i] === 1'b1) dones++;
      if (first_se0 >= 0 && obs_se[i] === 1'b1) eop_shifts++;
    end
    for (int i = last_se0 + 1; i >= 1 && i < last; i++) if (obs_line[i] === LJ) jcnt++;
    checks++;
    if (se0 != 2 * CPB) begin errors++; $display("FAIL eop_se0_len: %0d required %0d", se0, 2 * CPB); end
    checks++;
    if (jcnt != CPB) begin errors++; $display("FAIL eop_j_len: %0d required %0d", jcnt, CPB); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL eop_done_count: %0d required 1", dones); end
    checks++;
    if (eop_shifts != 0) begin errors++; $display("FAIL eop_shift: %0d pulses required 0", eop_shifts); end
    checks++;
    if (last < 1 || obs_done[last-1] !== 1'b1 || obs_busy[last-1] !== 1'b1 || obs_busy[last] !== 1'b0) begin
      errors++; $display("FAIL eop_busy_fall: done/busy at end not 1,1 then busy 0 (last=%0d)", last);
    end
  endtask

  task automatic test_stuff_before_eop();
    int n, bad = 0;
    pkt = '{1, 1, 1, 1, 1, 1};
    sym_line = '{LJ, LJ, LJ, LJ, LJ, LJ, LK, LSE0, LSE0, LJ};
    sym_data = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    run_packet(0);
    n = CPB * sym_line.size() + CPB + 1;
    checks++;
    if (obs_line.size() != n) begin
      errors++; $display("FAIL stuff_eop_length: %0d samples, required %0d", obs_line.size(), n);
    end
    for (int s = 1; s <= obs_line.size() && s <= n && bad < 8; s++) begin
      checks++;
      if (obs_line[s-1] !== exp_line(s)) begin
        errors++; bad++; $display("FAIL stuff_eop_line s=%0d: %b required %b", s, obs_line[s-1], exp_line(s));
      end
      checks++;
      if (obs_se[s-1] !== exp_se(s)) begin
        errors++; bad++; $display("FAIL stuff_eop_shift s=%0d: %b required %b", s, obs_se[s-1], exp_se(s));
      end
    end
  endtask

  // Random packets (biased toward 1s to hit stuffing), optionally with a tx_start while busy.
  task automatic test_random(input int npkts, input int inject_at);
    for (int p = 0; p < npkts; p++) begin
      int n, bad = 0;
      pkt.delete();
      repeat ($urandom_range(1, 40)) pkt.push_back($urandom_range(0, 3) != 0);
      if (inject_at > 0) while (pkt.size() < 10) pkt.push_back(1'b0);
      build_model();
      run_packet(inject_at);
      n = CPB * sym_line.size() + CPB + 1;
      checks++;
      if (obs_line.size() != n) begin
        errors++; $display("FAIL rand%0d_length: %0d samples, required %0d", p, obs_line.size(), n);
      end
      for (int s = 1; s <= obs_line.size() && s <= n && bad < 8; s++) begin
        checks++;
        if (obs_line[s-1] !== exp_line(s)) begin
          errors++; bad++; $display("FAIL rand%0d_line s=%0d: %b required %b", p, s, obs_line[s-1], exp_line(s));
        end
        checks++;
        if (obs_se[s-1] !== exp_se(s)) begin
          errors++; bad++; $display("FAIL rand%0d_shift s=%0d: %b required %b", p, s, obs_se[s-1], exp_se(s));
        end
        checks++;
        if (obs_done[s-1] !== exp_done(s)) begin
          errors++; bad++; $display("FAIL rand%0d_done s=%0d: %b required %b", p, s, obs_done[s-1], exp_done(s));
        end
        checks++;
        if (obs_busy[s-1] !== exp_busy(s)) begin
          errors++; bad++; $display("FAIL rand%0d_busy s=%0d: %b required %b", p, s, obs_busy[s-1], exp_busy(s));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    tx_start = 1'b1; serial_in = 1'b0; send_eop = 1'b0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (8) @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (12) @(posedge clk);
    checks++;
    if ({dplus_out, dminus_out, tx_busy} !== 3'b011) begin
      errors++; $display("FAIL mid_packet_pre: dp,dm,busy=%b required 011", {dplus_out, dminus_out, tx_busy});
    end
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if ({dplus_out, dminus_out, tx_busy, shift_enable, eop_done} !== 5'b10000) begin
      errors++; $display("FAIL mid_packet_reset: dp,dm,busy,se,done=%b required 10000",
                         {dplus_out, dminus_out, tx_busy, shift_enable, eop_done});
    end
    @(negedge clk);
    n_rst = 1'b1;
    test_random(1, 0);
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuffing();
    test_eop();
    test_stuff_before_eop();
    test_random(6, 0);
    test_random(2, 20);
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
